turn_sequencer: RTL and testbench

Game-flow controller for the Chicken Cha Cha Cha board. It sequences the card-match and move datapath through each turn:
- waits for a card flip;
- requests the same-card check;
- advances the piece on a match and tests for a win;
- otherwise holds the revealed card, then rotates the turn to the next player.

It owns the current-player index `T` and the consecutive-match combo count.

---
 rtl/turn_sequencer.sv | 172 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// turn_sequencer: per-turn game flow (flip -> check -> move/win or reveal -> next player).
// Optional build macro TURN_TIMEOUT_EN adds an idle-turn timeout in WAIT_FLIP.
module turn_sequencer #(
    parameter int unsigned REVEAL_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] N,
    input  logic       flip,
    input  logic       go,
    input  logic       W,
    output logic       check_req,
    output logic       move_en,
    output logic       next_turn,
    output logic [1:0] T,
    output logic [3:0] combo,
    output logic       reveal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       busy
);
    localparam int unsigned RCW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_FLIP,
        S_CHECK,
        S_EVAL,
        S_MOVE,
        S_WIN_EVAL,
        S_REVEAL,
        S_NEXT,
        S_OVER
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_T;
    logic [1:0]     w_T_nxt;
    logic [1:0]     r_nq;
    logic [1:0]     w_nq_nxt;
    logic [1:0]     r_winner;
    logic [1:0]     w_winner_nxt;
    logic [3:0]     r_combo;
    logic [3:0]     w_combo_nxt;
    logic [RCW-1:0] r_rcnt;
    logic [RCW-1:0] w_rcnt_nxt;
    logic           w_timeout;

`ifdef TURN_TIMEOUT_EN
    logic [28:0] r_tcnt;

    // Held at zero outside WAIT_FLIP, so it reads 0 on every entry.
    always_ff @(posedge clk) begin
        if (!rst || r_state != S_WAIT_FLIP) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 29'd1;
        end
    end

    assign w_timeout = (r_state == S_WAIT_FLIP) && (r_tcnt == 29'(TIMEOUT_CYCLES - 1));
`else
    // Timeout not built; parameter kept so instantiations stay identical.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_T      <= '0;
            r_nq     <= 2'd1;
            r_winner <= '0;
            r_combo  <= '0;
            r_rcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_T      <= w_T_nxt;
            r_nq     <= w_nq_nxt;
            r_winner <= w_winner_nxt;
            r_combo  <= w_combo_nxt;
            r_rcnt   <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_T_nxt      = r_T;
        w_nq_nxt     = r_nq;
        w_winner_nxt = r_winner;
        w_combo_nxt  = r_combo;
        w_rcnt_nxt   = r_rcnt;
        check_req    = 1'b0;
        move_en      = 1'b0;
        next_turn    = 1'b0;
        reveal       = 1'b0;
        game_over    = 1'b0;
        busy         = 1'b1;

        unique case (r_state)
            S_IDLE, S_OVER: begin
                busy      = 1'b0;
                game_over = (r_state == S_OVER);
                if (start) begin
                    w_state_nxt  = S_WAIT_FLIP;
                    w_nq_nxt     = (N == 2'd0) ? 2'd1 : N;
                    w_T_nxt      = '0;
                    w_combo_nxt  = '0;
                    w_winner_nxt = '0;
                end
            end
            S_WAIT_FLIP: begin
                if (flip) begin
                    w_state_nxt = S_CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_CHECK: begin
                check_req   = 1'b1;
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (go) begin
                    w_state_nxt = S_MOVE;
                end else begin
                    w_state_nxt = S_REVEAL;
                    w_rcnt_nxt  = RCW'(REVEAL_CYCLES - 1);
                end
            end
            S_MOVE: begin
                move_en     = 1'b1;
                w_state_nxt = S_WIN_EVAL;
            end
            S_WIN_EVAL: begin
                if (W) begin
                    w_state_nxt  = S_OVER;
                    w_winner_nxt = r_T;
                end else begin
                    w_state_nxt = S_WAIT_FLIP;
                    w_combo_nxt = (r_combo == 4'hF) ? r_combo : r_combo + 4'd1;
                end
            end
            S_REVEAL: begin
                reveal = 1'b1;
                if (r_rcnt == '0) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_rcnt_nxt = r_rcnt - 1'b1;
                end
            end
            S_NEXT: begin
                next_turn   = 1'b1;
                w_combo_nxt = '0;
                w_T_nxt     = (r_T == r_nq) ? 2'd0 : r_T + 2'd1;
                w_state_nxt = S_WAIT_FLIP;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign T      = r_T;
    assign combo  = r_combo;
    assign winner = r_winner;
endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: a timeline model (expected strobes/levels keyed by cycle
// number, filled from the turn timing rules) checked every cycle, plus literal spot checks.
module tb_turn_sequencer;
    localparam int RC = 4;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] N = 2'd0;
    logic       flip = 1'b0;
    logic       go = 1'b0;
    logic       W = 1'b0;
    logic       check_req, move_en, next_turn, reveal, game_over, busy;
    logic [1:0] T, winner;
    logic [3:0] combo;

    turn_sequencer #(.REVEAL_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .flip(flip), .go(go), .W(W),
        .check_req(check_req), .move_en(move_en), .next_turn(next_turn), .T(T),
        .combo(combo), .reveal(reveal), .game_over(game_over), .winner(winner), .busy(busy)
    );

    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int en_from = 1 << 30;

    // Expected timeline: strobe sets and level updates keyed by edge count.
    bit s_chk[int];
    bit s_mv[int];
    bit s_nt[int];
    bit s_rv[int];
    int u_T[int];
    int u_combo[int];
    int u_win[int];
    int u_over[int];
    int u_busy[int];
    int m_T, m_combo, m_win, m_over, m_busy;
    int p_T, p_combo, p_nq;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, ec, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ec >= en_from) begin
            if (u_T.exists(ec))     m_T     = u_T[ec];
            if (u_combo.exists(ec)) m_combo = u_combo[ec];
            if (u_win.exists(ec))   m_win   = u_win[ec];
            if (u_over.exists(ec))  m_over  = u_over[ec];
            if (u_busy.exists(ec))  m_busy  = u_busy[ec];
            chk("check_req", int'(check_req), s_chk.exists(ec));
            chk("move_en",   int'(move_en),   s_mv.exists(ec));
            chk("next_turn", int'(next_turn), s_nt.exists(ec));
            chk("reveal",    int'(reveal),    s_rv.exists(ec));
            chk("T",         int'(T),         m_T);
            chk("combo",     int'(combo),     m_combo);
            chk("winner",    int'(winner),    m_win);
            chk("game_over", int'(game_over), m_over);
            chk("busy",      int'(busy),      m_busy);
        end
    end

    function automatic void purge(input int r);
        for (int i = r; i < r + 512; i++) begin
            if (s_chk.exists(i))   s_chk.delete(i);
            if (s_mv.exists(i))    s_mv.delete(i);
            if (s_nt.exists(i))    s_nt.delete(i);
            if (s_rv.exists(i))    s_rv.delete(i);
            if (u_T.exists(i))     u_T.delete(i);
            if (u_combo.exists(i)) u_combo.delete(i);
            if (u_win.exists(i))   u_win.delete(i);
            if (u_over.exists(i))  u_over.delete(i);
            if (u_busy.exists(i))  u_busy.delete(i);
        end
    endfunction

    task automatic wait_until(input int t);
        while (ec < t) @(negedge clk);
    endtask

    task automatic do_reset();
        int r;
        @(negedge clk);
        rst = 1'b0;
        r = ec + 1;
        purge(r);
        u_T[r] = 0; u_combo[r] = 0; u_win[r] = 0; u_over[r] = 0; u_busy[r] = 0;
        p_T = 0; p_combo = 0; p_nq = 1;
        if (en_from > r) en_from = r;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start(input int n);
        int k;
        @(negedge clk);
        start = 1'b1;
        N = 2'(n);
        k = ec + 1;
        p_nq = (n == 0) ? 1 : n;
        p_T = 0; p_combo = 0;
        u_T[k] = 0; u_combo[k] = 0; u_win[k] = 0; u_over[k] = 0; u_busy[k] = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Input pulse the DUT must ignore in its current state (no timeline entries added).
    task automatic poke(input bit f, input bit s, input int n);
        @(negedge clk);
        flip = f; start = s; N = 2'(n); go = 1'b1; W = 1'b1;
        @(negedge clk);
        flip = 1'b0; start = 1'b0;
    endtask

    // One flip. rst_after > 0 pulls reset that many cycles after the flip edge.
    task automatic turn(input bit go_v, input bit w_v, input bit inject, input int rst_after);
        int k, done;
        @(negedge clk);
        flip = 1'b1; go = go_v; W = w_v;
        k = ec + 1;
        s_chk[k] = 1'b1;
        if (go_v) begin
            s_mv[k+2] = 1'b1;
            if (w_v) begin
                u_over[k+4] = 1; u_busy[k+4] = 0; u_win[k+4] = p_T;
            end else begin
                p_combo = (p_combo < 15) ? p_combo + 1 : 15;
                u_combo[k+4] = p_combo;
            end
            done = k + 3;
        end else begin
            for (int i = 0; i < RC; i++) s_rv[k+2+i] = 1'b1;
            s_nt[k+2+RC] = 1'b1;
            p_T = (p_T + 1) % (p_nq + 1);
            p_combo = 0;
            u_T[k+3+RC] = p_T; u_combo[k+3+RC] = 0;
            done = k + 2 + RC;
        end
        @(negedge clk);
        flip = 1'b0;
        if (rst_after > 0) begin
            wait_until(k + rst_after);
            do_reset();
        end else begin
            if (inject && !go_v) begin
                wait_until(k + 3);
                flip = 1'b1;
                @(negedge clk);
                flip = 1'b0;
            end
            wait_until(done);
        end
    endtask

    initial begin
        do_reset();
        chk("rst_T", int'(T), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_over", int'(game_over), 0);

        do_start(2);
        chk("start_T", int'(T), 0);
        chk("start_busy", int'(busy), 1);
        chk("start_combo", int'(combo), 0);
        go = 1'b1; W = 1'b1;
        wait_until(ec + 8);

        for (int i = 0; i < 3; i++) turn(1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("combo3", int'(combo), 3);
        chk("combo3_T", int'(T), 0);

        poke(1'b0, 1'b1, 1);
        turn(1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("mis1_T", int'(T), 1);
        chk("mis1_combo", int'(combo), 0);
        turn(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("mis2_T", int'(T), 2);
        turn(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("mis3_T", int'(T), 0);

        turn(1'b0, 1'b0, 1'b0, 0);
        turn(1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("win_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 1);
        chk("win_busy", int'(busy), 0);
        poke(1'b1, 1'b0, 0);
        poke(1'b1, 1'b0, 0);

        do_start(0);
        chk("restart_T", int'(T), 0);
        chk("restart_combo", int'(combo), 0);
        chk("restart_winner", int'(winner), 0);
        turn(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("n0_T1", int'(T), 1);
        turn(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("n0_T0", int'(T), 0);
        turn(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("n0_T1b", int'(T), 1);
        for (int i = 0; i < 16; i++) turn(1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("combo_sat", int'(combo), 15);

        turn(1'b0, 1'b0, 1'b0, 4);
        chk("rstmid_T", int'(T), 0);
        chk("rstmid_reveal", int'(reveal), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_combo", int'(combo), 0);

`ifdef TURN_TIMEOUT_EN
        begin
            int k;
            do_start(1);
            k = ec;
            s_nt[k+TO] = 1'b1;
            u_T[k+TO+1] = 1; u_combo[k+TO+1] = 0;
            wait_until(k + TO + 2);
            chk("timeout_T", int'(T), 1);
        end
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", ec);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
